xreq_splitter: RTL and testbench
================================

Name: xreq_splitter

Overview:
- Buffered request downsizer. Accepts one wide write/read request (DWI data bits plus byte strobe) and issues it as a sequence of narrow DWO-wide beats on a valid/ready interface.
- Sits between a wide initiator port and a narrow target port of the switch, in place of the non-buffered sizer where a ratio greater than 1:1 must be serialized.
- Beats whose strobe slice is all-zero are skipped.

Parameters:
- AW, 19: address width in bits.
- DWI, 64: input data width in bits. Power of 2, at least 16.
- DWO, 32: output data width in bits. Power of 2, at least 8, and DWO < DWI.
- Derived R = DWI/DWO: number of lanes.
- Derived LO = log2(DWO/8).
- Derived LI = log2(DWI/8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_vld_i  in  1  input request valid.
- req_rdy_o  out  1  input request ready.
- req_adr_i  in  AW  input byte address.
- req_dat_i  in  DWI  input data.
- req_strb_i  in  DWI/8  input byte strobes.
- req_vld_o  out  1  output beat valid.
- req_rdy_i  in  1  output beat ready.
- req_adr_o  out  AW  beat byte address.
- req_dat_o  out  DWO  beat data.
- req_strb_o  out  DWO/8  beat byte strobes.
- req_last_o  out  1  final beat of the current request.

Behaviour:
- **Clock and reset.** One clock, clk_i. Reset rst_i is synchronous and active-high.
- **Reset values.** req_vld_o=0, req_last_o=0, req_adr_o=0, req_dat_o=0, req_strb_o=0, internal lane mask=0, busy=0. While rst_i=1, req_rdy_o=0.
- **Storage.** One request register holds: address, data, and an R-bit lane mask. Mask bit k = OR of strobe slice k.
  - If all strobes are zero (read or no-op), the mask is set to exactly one bit: lane (adr[LI-1:LO]).
- **Input handshake.** req_rdy_o = !busy OR (req_vld_o AND req_rdy_i AND req_last_o). This is combinational from state and req_rdy_i.
  - Accept occurs when req_vld_i AND req_rdy_o.
  - On accept, the request is captured and busy=1.
- **Latency.** The first beat is valid on the cycle after accept. There is no combinational path from req_vld_i to req_vld_o.
- **Beat selection.** The current lane k = lowest set bit of the mask, so lanes are issued in ascending order. For each beat:
  - req_adr_o = {adr[AW-1:LI], k, LO zeros}
  - req_dat_o = dat[k*DWO +: DWO]
  - req_strb_o = strb[k*DWO/8 +: DWO/8]
  - req_last_o = 1 when the mask has exactly one bit set.
- **Address bits.** Input address bits [LI-1:0] are ignored, except for selecting the lane of an all-zero-strobe request.
- **Output handshake.** A beat transfers when req_vld_o AND req_rdy_i; bit k is then cleared from the mask.
  - On transfer of the last beat, busy=0, unless a new request is accepted in the same cycle.
  - If a new request is accepted in that cycle, its first beat is presented on the next cycle, with no bubble.
- **Stability.** While req_vld_o=1 and req_rdy_i=0, all req_*_o outputs are held stable. req_vld_o is never deasserted without a transfer, except on reset.
- **Reset mid-operation.** Remaining beats are discarded. req_vld_o=0 on the cycle after rst_i is sampled high. req_rdy_o=1 on the first cycle with rst_i=0.
- **Throughput.**
  - Best case, one input request per cycle when every request has a single active lane.
  - Otherwise one beat per cycle with req_rdy_i held high.
- **Protocol rule.** req_vld_i may be asserted while req_rdy_o=0. The upstream holds its payload until accept; the block does not check this.

Test Plan (DWI=64, DWO=32, AW=19):
1. Full write: adr=0x00010, strb=0xFF, dat=0x1122334455667788, req_rdy_i=1 → beat0 adr=0x00010, dat=0x55667788, strb=0xF, last=0; beat1 adr=0x00014, dat=0x11223344, strb=0xF, last=1; beats on consecutive cycles.
2. Sparse write: adr=0x00020, strb=0x30 → single beat adr=0x00024, dat=upper word, strb=0x3, last=1; lane 0 skipped.
3. Read (strb=0x00): adr=0x0001C → single beat adr=0x0001C, strb=0x0, dat=upper word, last=1.
4. Backpressure: scenario 1 with req_rdy_i=0 for 3 cycles at beat0 → adr/dat/strb/last frozen, req_rdy_o=0 throughout, beat1 follows after release.
5. Back-to-back: second request (strb=0x0F) offered during beat1 of scenario 1 → accepted in the same cycle as the beat1 transfer; its beat (adr=lane 0, last=1) is valid on the next cycle, no idle cycle.
6. Reset mid-op: rst_i=1 for one cycle while beat0 is stalled → req_vld_o=0 the next cycle, beat1 never appears, req_rdy_o=1 once rst_i=0.

Source files
------------

// File: rtl/xreq_splitter.sv
// xreq_splitter: buffered request downsizer.
// Captures one wide request (DWI data + byte strobes) and replays it as a
// sequence of DWO-wide beats on a valid/ready interface. Lanes are issued in
// ascending order, and lanes whose strobe slice is all-zero are skipped. A
// request with no strobes at all (read/no-op) issues the single lane selected
// by its address.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_vld_i/req_rdy_o   wide request handshake
//   req_adr_i/dat_i/strb_i wide request payload
//   req_vld_o/req_rdy_i   narrow beat handshake
//   req_adr_o/dat_o/strb_o narrow beat payload
//   req_last_o            final beat of the current request
module xreq_splitter #(
    parameter int unsigned AW  = 19,
    parameter int unsigned DWI = 64,
    parameter int unsigned DWO = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_vld_i,
    output logic                 req_rdy_o,
    input  logic [AW-1:0]        req_adr_i,
    input  logic [DWI-1:0]       req_dat_i,
    input  logic [DWI/8-1:0]     req_strb_i,
    output logic                 req_vld_o,
    input  logic                 req_rdy_i,
    output logic [AW-1:0]        req_adr_o,
    output logic [DWO-1:0]       req_dat_o,
    output logic [DWO/8-1:0]     req_strb_o,
    output logic                 req_last_o
);

    localparam int unsigned R  = DWI / DWO;
    localparam int unsigned LO = $clog2(DWO / 8);
    localparam int unsigned LI = $clog2(DWI / 8);
    localparam int unsigned LW = LI - LO;
    localparam int unsigned SI = DWI / 8;
    localparam int unsigned SO = DWO / 8;
    localparam int unsigned AH = AW - LI;

    // Stored request; only the address bits above the wide word are kept.
    logic [AH-1:0]  adr_hi_q, adr_hi_d;
    logic [DWI-1:0] dat_q, dat_d;
    logic [SI-1:0]  strb_q, strb_d;
    logic [R-1:0]   mask_q, mask_d;
    logic           busy_q, busy_d;

    // Registered beat presented on the output.
    logic [AW-1:0]  out_adr_q, out_adr_d;
    logic [DWO-1:0] out_dat_q, out_dat_d;
    logic [SO-1:0]  out_strb_q, out_strb_d;
    logic           out_last_q, out_last_d;

    logic           xfer_c;
    logic           accept_c;
    logic [R-1:0]   mask_in_c;
    logic [R-1:0]   cur_lsb_c;
    logic [LW-1:0]  lane_d;
    logic           unused_adr;

    // Low address bits only matter through the lane field.
    assign unused_adr = ^req_adr_i;

    assign xfer_c    = busy_q & req_rdy_i;
    assign req_rdy_o = !rst_i && (!busy_q || (xfer_c && out_last_q));
    assign accept_c  = req_vld_i & req_rdy_o;

    // Lane mask of the incoming request; strobe-less requests pick one lane by address.
    always_comb begin
        mask_in_c = '0;
        for (int i = 0; i < int'(R); i++) begin
            mask_in_c[i] = |req_strb_i[i*SO +: SO];
        end
        if (!(|req_strb_i)) begin
            mask_in_c = R'(1) << req_adr_i[LI-1:LO];
        end
    end

    // Isolate the lowest set bit: the lane currently on the output.
    assign cur_lsb_c = mask_q & (~mask_q + R'(1));

    // Next request state and the beat to present next cycle.
    always_comb begin
        adr_hi_d   = adr_hi_q;
        dat_d      = dat_q;
        strb_d     = strb_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        lane_d     = '0;
        out_dat_d  = '0;
        out_strb_d = '0;

        if (accept_c) begin
            adr_hi_d = req_adr_i[AW-1:LI];
            dat_d    = req_dat_i;
            strb_d   = req_strb_i;
            mask_d   = mask_in_c;
            busy_d   = 1'b1;
        end else if (xfer_c) begin
            mask_d = mask_q & ~cur_lsb_c;
            if (out_last_q) begin
                busy_d = 1'b0;
            end
        end

        // Lowest set lane of the next mask, ascending issue order.
        for (int i = int'(R) - 1; i >= 0; i--) begin
            if (mask_d[i]) begin
                lane_d = LW'(i);
            end
        end

        for (int i = 0; i < int'(R); i++) begin
            if (lane_d == LW'(i)) begin
                out_dat_d  = dat_d[i*DWO +: DWO];
                out_strb_d = strb_d[i*SO +: SO];
            end
        end

        out_adr_d  = AW'({adr_hi_d, lane_d}) << LO;
        out_last_d = (mask_d != '0) && ((mask_d & (mask_d - R'(1))) == '0);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_hi_q   <= '0;
            dat_q      <= '0;
            strb_q     <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            out_adr_q  <= '0;
            out_dat_q  <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            adr_hi_q   <= adr_hi_d;
            dat_q      <= dat_d;
            strb_q     <= strb_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            out_adr_q  <= out_adr_d;
            out_dat_q  <= out_dat_d;
            out_strb_q <= out_strb_d;
            out_last_q <= out_last_d;
        end
    end

    assign req_vld_o  = busy_q;
    assign req_adr_o  = out_adr_q;
    assign req_dat_o  = out_dat_q;
    assign req_strb_o = out_strb_q;
    assign req_last_o = out_last_q;

endmodule

// File: tb/tb_xreq_splitter.sv
// Testbench for xreq_splitter (AW=19, DWI=64, DWO=32): directed scenarios
// with a beat scoreboard filled at request accept and drained by a monitor.
module tb_xreq_splitter;

    localparam int unsigned AW  = 19;
    localparam int unsigned DWI = 64;
    localparam int unsigned DWO = 32;
    localparam int unsigned SI  = DWI / 8;
    localparam int unsigned SO  = DWO / 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_vld_i;
    logic             req_rdy_o;
    logic [AW-1:0]    req_adr_i;
    logic [DWI-1:0]   req_dat_i;
    logic [SI-1:0]    req_strb_i;
    logic             req_vld_o;
    logic             req_rdy_i;
    logic [AW-1:0]    req_adr_o;
    logic [DWO-1:0]   req_dat_o;
    logic [SO-1:0]    req_strb_o;
    logic             req_last_o;

    typedef struct packed {
        logic [AW-1:0]  adr;
        logic [DWO-1:0] dat;
        logic [SO-1:0]  strb;
        logic           last;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;

    xreq_splitter #(.AW(AW), .DWI(DWI), .DWO(DWO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_vld_i  (req_vld_i),
        .req_rdy_o  (req_rdy_o),
        .req_adr_i  (req_adr_i),
        .req_dat_i  (req_dat_i),
        .req_strb_i (req_strb_i),
        .req_vld_o  (req_vld_o),
        .req_rdy_i  (req_rdy_i),
        .req_adr_o  (req_adr_o),
        .req_dat_o  (req_dat_o),
        .req_strb_o (req_strb_o),
        .req_last_o (req_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected beats of one request: active 32-bit lanes in ascending order,
    // or the addressed lane when no strobe is set.
    task automatic push_model(input logic [AW-1:0] a, input logic [DWI-1:0] d,
                              input logic [SI-1:0] s);
        beat_t b;
        int    n = 0;
        for (int l = 0; l < 2; l++) begin
            logic [SO-1:0] sl;
            sl = s[l*SO +: SO];
            if (sl != '0 || (s == '0 && int'(a[2]) == l)) begin
                b.adr  = (a & ~AW'(7)) | AW'(l * 4);
                b.dat  = d[l*DWO +: DWO];
                b.strb = sl;
                b.last = 1'b0;
                sb.push_back(b);
                n++;
            end
        end
        if (n > 0) begin
            b = sb.pop_back();
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    // Offer a request, wait (bounded) for acceptance, record its expected beats.
    task automatic offer(input logic [AW-1:0] a, input logic [DWI-1:0] d,
                         input logic [SI-1:0] s);
        int n = 0;
        req_vld_i  = 1'b1;
        req_adr_i  = a;
        req_dat_i  = d;
        req_strb_i = s;
        @(negedge clk_i);
        while (!req_rdy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_rdy_o) begin
            tests++;
            fails++;
            $error("FAIL accept_timeout observed rdy=0 expected rdy=1 adr=%h", a);
        end else begin
            push_model(a, d, s);
        end
        tick();
        req_vld_i = 1'b0;
    endtask

    // Scoreboard monitor: compare every transferring beat.
    always @(negedge clk_i) begin
        if (!rst_i && req_vld_o && req_rdy_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_beat observed adr=%h dat=%h expected none",
                       req_adr_o, req_dat_o);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat", 64'({req_adr_o, req_dat_o, req_strb_o, req_last_o}), 64'(e));
            end
        end
    end

    initial begin
        rst_i      = 1'b1;
        req_vld_i  = 1'b0;
        req_rdy_i  = 1'b1;
        req_adr_i  = '0;
        req_dat_i  = '0;
        req_strb_i = '0;
        tick();
        tick();
        @(negedge clk_i);
        chk("rst_vld", 64'(req_vld_o), 64'(0));
        chk("rst_rdy", 64'(req_rdy_o), 64'(0));
        chk("rst_payload", 64'({req_adr_o, req_dat_o, req_strb_o, req_last_o}), 64'(0));
        tick();
        rst_i = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(req_rdy_o), 64'(1));

        // Full write, two beats back to back.
        offer(19'h00010, 64'h1122334455667788, 8'hFF);
        chk("full_b0_vld", 64'(req_vld_o), 64'(1));
        chk("full_b0_adr", 64'(req_adr_o), 64'h10);
        tick();
        chk("full_b1_adr", 64'(req_adr_o), 64'h14);
        chk("full_b1_last", 64'(req_last_o), 64'(1));
        tick();
        chk("full_idle", 64'(req_vld_o), 64'(0));

        // Sparse write, lane 0 skipped.
        offer(19'h00020, 64'hAABBCCDDEEFF0011, 8'h30);
        chk("sparse_adr", 64'(req_adr_o), 64'h24);
        chk("sparse_dat", 64'(req_dat_o), 64'hAABBCCDD);
        tick();

        // Read: no strobes, lane chosen by address bit 2.
        offer(19'h0001C, 64'hCAFEF00D12345678, 8'h00);
        chk("read_adr", 64'(req_adr_o), 64'h1C);
        chk("read_strb", 64'(req_strb_o), 64'(0));
        chk("read_last", 64'(req_last_o), 64'(1));
        tick();

        // Backpressure: beat 0 must hold for three cycles.
        req_rdy_i = 1'b0;
        offer(19'h00010, 64'h1122334455667788, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("bp_hold", 64'({req_vld_o, req_adr_o, req_dat_o, req_strb_o, req_last_o}),
                64'({1'b1, 19'h00010, 32'h55667788, 4'hF, 1'b0}));
            chk("bp_rdy", 64'(req_rdy_o), 64'(0));
            tick();
        end
        req_rdy_i = 1'b1;
        tick();
        chk("bp_b1_adr", 64'(req_adr_o), 64'h14);
        tick();
        chk("bp_idle", 64'(req_vld_o), 64'(0));

        // Back-to-back: next request accepted with the last beat, no bubble.
        offer(19'h00010, 64'h1122334455667788, 8'hFF);
        tick();
        req_vld_i  = 1'b1;
        req_adr_i  = 19'h00040;
        req_dat_i  = 64'h0BADBEEF600DD00D;
        req_strb_i = 8'h0F;
        @(negedge clk_i);
        chk("b2b_last", 64'({req_vld_o, req_last_o}), 64'(3));
        chk("b2b_rdy", 64'(req_rdy_o), 64'(1));
        push_model(19'h00040, 64'h0BADBEEF600DD00D, 8'h0F);
        tick();
        req_vld_i = 1'b0;
        chk("b2b_next", 64'({req_vld_o, req_adr_o, req_last_o}), 64'({1'b1, 19'h00040, 1'b1}));
        tick();
        chk("b2b_idle", 64'(req_vld_o), 64'(0));

        // Single-lane requests at one per cycle.
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0]  a;
            logic [DWI-1:0] d;
            a = AW'($urandom);
            d = {$urandom, $urandom};
            offer(a, d, (i % 2 == 0) ? 8'h0C : 8'h00);
            chk("stream_vld", 64'(req_vld_o), 64'(1));
        end
        tick();
        chk("stream_idle", 64'(req_vld_o), 64'(0));

        // Reset while beat 0 is stalled: remaining beats are dropped.
        req_rdy_i = 1'b0;
        offer(19'h00010, 64'h1122334455667788, 8'hFF);
        tick();
        rst_i = 1'b1;
        #1;
        chk("rst_mid_rdy", 64'(req_rdy_o), 64'(0));
        tick();
        rst_i = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_vld", 64'(req_vld_o), 64'(0));
        chk("rst_mid_rdy1", 64'(req_rdy_o), 64'(1));
        req_rdy_i = 1'b1;
        tick();
        tick();
        chk("rst_mid_quiet", 64'(req_vld_o), 64'(0));

        // Recovery after reset.
        offer(19'h00030, 64'h0123456789ABCDEF, 8'hF3);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
